// File: rtl/vga_text_renderer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_text_renderer_pkg                                                |
// | Text-mode geometry, cell layout and cell indexing shared by the      |
// | renderer and its font ROM.                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_text_renderer_pkg;

  localparam int COLS     = 80;
  localparam int ROWS     = 30;
  localparam int CELLS    = COLS * ROWS;
  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 16;
  localparam int H_PIXELS = COLS * GLYPH_W;
  localparam int V_PIXELS = ROWS * GLYPH_H;
  localparam int ADDR_W   = 12;

  localparam logic [7:0] BG_COLOR = 8'h00;

  localparam int CELL_FG_MSB   = 15;
  localparam int CELL_FG_LSB   = 8;
  localparam int CELL_CHAR_MSB = 7;
  localparam int CELL_CHAR_LSB = 0;

  typedef struct packed {
    logic [7:0] fg;
    logic [7:0] ch;
  } cell_t;

  // row*80 built as row*64 + row*16 so no multiplier is needed
  function automatic logic [ADDR_W-1:0] cell_index(input logic [4:0] row,
                                                   input logic [6:0] col);
    return ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0}) + ADDR_W'(col);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_renderer_font_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | font_rom                                                             |
// | 4096x8 glyph ROM, synchronous read, address {char, glyph row}.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module font_rom (
  input  logic        clk,
  input  logic [11:0] addr,
  output logic [7:0]  data
);

  // Codes without a drawn glyph get a row-dependent filler pattern
  function automatic logic [7:0] glyph_row(input logic [7:0] ch,
                                           input logic [3:0] row);
    logic [7:0] bits;
    bits = ch ^ {row, row};
    case (ch)
      8'h20: bits = 8'h00;
      8'h41: begin
        case (row)
          4'd0:    bits = 8'h18;
          4'd1:    bits = 8'h3C;
          4'd2:    bits = 8'h66;
          4'd3:    bits = 8'h66;
          4'd4:    bits = 8'h7E;
          4'd5:    bits = 8'h66;
          4'd6:    bits = 8'h66;
          4'd7:    bits = 8'h66;
          default: bits = 8'h00;
        endcase
      end
      8'h42: begin
        case (row)
          4'd0:    bits = 8'hFC;
          4'd1:    bits = 8'h66;
          4'd2:    bits = 8'h66;
          4'd3:    bits = 8'h7C;
          4'd4:    bits = 8'h66;
          4'd5:    bits = 8'h66;
          4'd6:    bits = 8'hFC;
          default: bits = 8'h00;
        endcase
      end
      8'hDB:   bits = 8'hFF;
      default: ;
    endcase
    return bits;
  endfunction

  always_ff @(posedge clk) begin
    data <= glyph_row(addr[11:4], addr[3:0]);
  end

endmodule
`default_nettype wire

// File: rtl/vga_text_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_text_renderer                                                    |
// | 80x30 text-mode pixel generator, 3-stage pipeline (addr, RAM, font). |
// | Optional blinking underline cursor when CURSOR_EN is defined.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_text_renderer #(
  parameter int LOOKAHEAD    = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        cur_wr,
  input  logic [11:0] cur_addr,
  output logic [7:0]  color
);
  import vga_text_renderer_pkg::*;

  logic [10:0]       w_xf;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_cell;
  logic [3:0]        w_row;
  logic [2:0]        w_bit;
  logic              w_cur_hit;

  assign w_xf       = {1'b0, x} + 11'(LOOKAHEAD);
  assign w_in_range = (w_xf < 11'(H_PIXELS)) && (y < 9'(V_PIXELS));
  assign w_cell     = cell_index(y[8:4], w_xf[9:3]);
  assign w_row      = y[3:0];
  assign w_bit      = ~w_xf[2:0];

`ifdef CURSOR_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [ADDR_W-1:0] r_cur_pos;
  logic [CNT_W-1:0]  r_blink_cnt;
  logic              r_cursor_vis;
  logic [9:0]        r_prev_x;
  logic [8:0]        r_prev_y;
  logic              w_frame_tick;

  assign w_frame_tick = (x == '0) && (y == '0) &&
                        ((r_prev_x != '0) || (r_prev_y != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_pos    <= '0;
      r_blink_cnt  <= '0;
      r_cursor_vis <= 1'b1;
      r_prev_x     <= '0;
      r_prev_y     <= '0;
    end else begin
      r_prev_x <= x;
      r_prev_y <= y;
      if (cur_wr && (cur_addr < ADDR_W'(CELLS))) begin
        r_cur_pos <= cur_addr;
      end
      if (w_frame_tick) begin
        if (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          r_blink_cnt  <= '0;
          r_cursor_vis <= ~r_cursor_vis;
        end else begin
          r_blink_cnt <= r_blink_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Underline occupies the bottom two glyph rows of the cursor cell
  assign w_cur_hit = r_cursor_vis && (w_cell == r_cur_pos) && (w_row[3:1] == 3'b111);
`else
  logic w_unused_cursor;
  assign w_unused_cursor = (^{cur_wr, cur_addr}) ^ (BLINK_FRAMES > 0);
  assign w_cur_hit       = 1'b0;
`endif

  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [3:0]        r_s1_row;
  logic [2:0]        r_s1_bit;
  logic              r_s1_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_row   <= '0;
      r_s1_bit   <= '0;
      r_s1_cur   <= 1'b0;
    end else begin
      r_s1_valid <= w_in_range;
      r_s1_addr  <= w_in_range ? w_cell : '0;
      r_s1_row   <= w_row;
      r_s1_bit   <= w_bit;
      r_s1_cur   <= w_in_range && w_cur_hit;
    end
  end

  // Text RAM has no reset; a read colliding with a write returns the old cell
  cell_t r_text_ram [CELLS];

  always_ff @(posedge clk) begin
    if (wr_en && !rst && (wr_addr < ADDR_W'(CELLS))) begin
      r_text_ram[wr_addr] <= cell_t'(wr_data);
    end
  end

  logic       r_s2_valid;
  cell_t      r_s2_cell;
  logic [3:0] r_s2_row;
  logic [2:0] r_s2_bit;
  logic       r_s2_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_cell  <= '0;
      r_s2_row   <= '0;
      r_s2_bit   <= '0;
      r_s2_cur   <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_cell  <= r_text_ram[r_s1_addr];
      r_s2_row   <= r_s1_row;
      r_s2_bit   <= r_s1_bit;
      r_s2_cur   <= r_s1_cur;
    end
  end

  logic [7:0] w_glyph;

  font_rom u_font_rom (
    .clk  (clk),
    .addr ({r_s2_cell[CELL_CHAR_MSB:CELL_CHAR_LSB], r_s2_row}),
    .data (w_glyph)
  );

  logic       r_s3_valid;
  logic [7:0] r_s3_fg;
  logic [2:0] r_s3_bit;
  logic       r_s3_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
      r_s3_fg    <= '0;
      r_s3_bit   <= '0;
      r_s3_cur   <= 1'b0;
    end else begin
      r_s3_valid <= r_s2_valid;
      r_s3_fg    <= r_s2_cell[CELL_FG_MSB:CELL_FG_LSB];
      r_s3_bit   <= r_s2_bit;
      r_s3_cur   <= r_s2_cur;
    end
  end

  // Decoded from reset registers so rst blanks the output immediately
  assign color = (r_s3_valid && (r_s3_cur || w_glyph[r_s3_bit])) ? r_s3_fg : BG_COLOR;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_text_renderer                                                 |
// | Directed stimulus with a pixel-level reference model of the display. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_text_renderer;

  localparam int LA = 4;
  localparam int BF = 2;

  localparam logic [7:0] A_ROWS [16] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66,
                                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] B_ROWS [16] = '{8'hFC, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'hFC, 8'h00,
                                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] FILL_CHARS [4] = '{8'h20, 8'h41, 8'h42, 8'hDB};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x = 10'd700;
  logic [8:0]  y = 9'd500;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        cur_wr = 1'b0;
  logic [11:0] cur_addr = '0;
  logic [7:0]  color;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  vga_text_renderer #(.LOOKAHEAD(LA), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cur_wr(cur_wr), .cur_addr(cur_addr), .color(color)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_font(input logic [7:0] ch, input int r);
    if (ch == 8'h20) return 8'h00;
    if (ch == 8'h41) return A_ROWS[r];
    if (ch == 8'h42) return B_ROWS[r];
    if (ch == 8'hDB) return 8'hFF;
    return ch ^ 8'(r * 17);
  endfunction

  function automatic logic [7:0] ref_pixel(input logic [15:0] c, input int r, input int col, input bit cur);
    logic [7:0] g;
    g = ref_font(c[7:0], r);
    if (cur || g[7 - col]) return c[15:8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] cursor_px();
`ifdef CURSOR_EN
    return 8'h1C;
`else
    return 8'h00;
`endif
  endfunction

  // Reference model: text contents, frame count, cursor, and a pixel delay line
  logic [15:0] mem_m [0:2399];
  bit          p1_v = 0;
  bit          p1_cur = 0;
  int          p1_cell, p1_row, p1_col, m_xf;
  int          frames = 0;
  int          cur_pos_m = 0;
  int          prev_x = 0, prev_y = 0;
  logic [7:0]  e2 = 8'h00, e3 = 8'h00;
  logic [7:0]  hist [0:4095];

  function automatic bit cursor_visible();
`ifdef CURSOR_EN
    return ((frames / BF) % 2) == 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_v = 0; p1_cur = 0; e2 = 8'h00; e3 = 8'h00;
      frames = 0; cur_pos_m = 0; prev_x = 0; prev_y = 0;
    end else begin
      e3 = e2;
      e2 = p1_v ? ref_pixel(mem_m[p1_cell], p1_row, p1_col, p1_cur) : 8'h00;
      if (wr_en && wr_addr < 2400) mem_m[wr_addr] = wr_data;
      m_xf = int'(x) + LA;
      p1_v = (m_xf < 640) && (y < 480);
      if (p1_v) begin
        p1_cell = (int'(y) / 16) * 80 + m_xf / 8;
        p1_row  = int'(y) % 16;
        p1_col  = m_xf % 8;
      end
      p1_cur = p1_v && cursor_visible() && (p1_cell == cur_pos_m) && (p1_row >= 14);
      if (x == 0 && y == 0 && (prev_x != 0 || prev_y != 0)) frames++;
      prev_x = int'(x);
      prev_y = int'(y);
      if (cur_wr && cur_addr < 2400) cur_pos_m = int'(cur_addr);
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: color=%02h expected=%02h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    hist[cyc % 4096] = color;
    if (cyc >= 2) check("pixel", color, e3);
  end

  int dcx [0:1023];

  task automatic px(input int xx, input int yy, output int dc);
    @(posedge clk);
    #1;
    x = xx[9:0];
    y = yy[8:0];
    wr_en = 1'b0;
    cur_wr = 1'b0;
    dc = cyc;
  endtask

  task automatic idle(input int n);
    int d;
    for (int i = 0; i < n; i++) px(700, 500, d);
  endtask

  task automatic scan(input int yy, input int x0, input int x1);
    int d;
    for (int xx = x0; xx <= x1; xx++) begin
      px(xx, yy, d);
      dcx[xx] = d;
    end
  endtask

  task automatic lit(input string nm, input int dc, input logic [7:0] exp);
    check(nm, hist[(dc + 3) % 4096], exp);
  endtask

  initial begin
    int d, d37, d38, d39, c30, c31;
    logic [7:0] vis_exp;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_color", color, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 2400; i++) begin
      px(700, 500, d);
      wr_en = 1'b1; wr_addr = 12'(i); wr_data = {8'(i * 7 + 3), FILL_CHARS[i % 4]};
    end
    px(700, 500, d); wr_en = 1'b1; wr_addr = 12'd0;  wr_data = 16'hE041;
    px(700, 500, d); wr_en = 1'b1; wr_addr = 12'd81; wr_data = 16'h1C20;
    idle(4);

    // 'A' in red at cell 0, glyph rows 0 and 3
    px(0, 0, d);
    scan(0, 0, 15);
    idle(4);
    lit("A_row0_x0", dcx[0], 8'hE0);
    lit("A_row0_x1", dcx[1], 8'h00);
    lit("A_row0_x3", dcx[3], 8'h00);
    lit("cell1_x7",  dcx[7], 8'h0A);
    lit("cell1_x8",  dcx[8], 8'h0A);
    lit("cell1_x9",  dcx[9], 8'h00);
    lit("cell2_x12", dcx[12], 8'h11);
    scan(3, 0, 7);
    idle(4);
    lit("A_row3_x0", dcx[0], 8'h00);
    lit("A_row3_x1", dcx[1], 8'hE0);

    // Right edge: fetch column past 639 must be background
    scan(0, 630, 639);
    px(100, 480, d);
    idle(4);
    lit("last_col",   dcx[635], 8'h2C);
    lit("xf_640",     dcx[636], 8'h00);
    lit("xf_642",     dcx[638], 8'h00);
    lit("y_480",      d, 8'h00);

    // Out-of-range write must not touch any cell
    px(700, 500, d); wr_en = 1'b1; wr_addr = 12'd2400; wr_data = 16'hFFFF;
    idle(2);
    scan(464, 626, 635);
    scan(64, 252, 259);
    idle(4);
    lit("cell2399_a", dcx[628], 8'h9C);
    lit("cell2399_b", dcx[635], 8'h9C);
    lit("cell352",    dcx[252], 8'h00);

    // Write to cell 5 colliding with its RAM read
    px(35, 2, d);
    px(36, 2, d);
    px(37, 2, d37);
    px(38, 2, d38); wr_en = 1'b1; wr_addr = 12'd5; wr_data = 16'hFFDB;
    px(39, 2, d39);
    px(40, 2, d);
    idle(4);
    lit("collide_old", d37, 8'h26);
    lit("after_new_a", d38, 8'hFF);
    lit("after_new_b", d39, 8'hFF);
    px(0, 0, d);
    scan(2, 36, 39);
    idle(4);
    lit("next_frame_new", dcx[36], 8'hFF);

    // Asynchronous reset mid-line, write during reset ignored
    scan(0, 70, 75);
    rst = 1'b1;
    #1 check("rst_async", color, 8'h00);
    wr_en = 1'b1; wr_addr = 12'd10; wr_data = 16'hFFDB;
    px(76, 0, d);
    px(77, 0, d);
    px(0, 0, d);
    rst = 1'b0;
    px(0, 0, d); cur_wr = 1'b1; cur_addr = 12'd81;
    scan(0, 76, 83);
    idle(4);
    lit("ram_kept_x76", dcx[76], 8'h49);
    lit("ram_kept_x82", dcx[82], 8'h00);

    // Frame 0 after reset: cursor visible, counter restarted
    scan(29, 2, 13);
    scan(30, 2, 13); c30 = dcx[4];
    d = dcx[12];
    scan(31, 2, 13); c31 = dcx[11];
    idle(4);
    lit("cur_f0_r30", c30, cursor_px());
    lit("cur_f0_r31", c31, cursor_px());
    lit("cur_nbr_col", d, 8'h00);

    for (int f = 1; f <= 4; f++) begin
      px(0, 0, d);
      scan(30, 2, 13); c30 = dcx[4];
      scan(31, 2, 13); c31 = dcx[11];
      idle(4);
      vis_exp = (f == 2 || f == 3) ? 8'h00 : cursor_px();
      lit($sformatf("cur_f%0d_r30", f), c30, vis_exp);
      lit($sformatf("cur_f%0d_r31", f), c31, vis_exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
